tcm_dport_responder: RTL and testbench

- Behavioural-plus-synthesisable responder for the core's data-memory port (mem_d_* protocol); it is the slave end of the interface the core drives.
- Replaces the fixed single-cycle data side of the TCM model in core benches with a tagged, queued, configurable-latency responder.
- Exercises the core's outstanding-request and tag-matching logic.
- Sits between riscv_core data outputs and the bench; the instruction port is out of scope.

---
 rtl/tcm_dport_responder.sv | 144 ++++++++++++++
 tb/tb_tcm_dport_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tcm_dport_responder.sv
// Data-port slave for the core's mem_d_* interface: a 32-bit word store with
// byte-enable writes and a tagged, in-order response FIFO. Each accepted
// request is acknowledged a fixed number of edges after acceptance.
module tcm_dport_responder #(
  parameter int          ADDR_BITS = 15,
  parameter logic [31:0] BASE_ADDR = 32'h80000000,
  parameter int          LATENCY   = 2,
  parameter int          DEPTH     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WORDS = 1 << ADDR_BITS;

  // Response FIFO state
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [10:0]      r_q_tag  [DEPTH];
  logic [31:0]      r_q_data [DEPTH];
  logic             r_q_err  [DEPTH];
  logic [3:0]       r_q_cd   [DEPTH];

  // Registered response outputs
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_data;
  logic [10:0] r_tag;

  logic                 w_req;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_is_wr;
  logic                 w_is_rd;
  logic [32:0]          w_offset;
  logic                 w_in_range;
  logic [ADDR_BITS-1:0] w_word_idx;
  logic [31:0]          w_rd_word;
  logic                 w_unused;

  assign w_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i
               | mem_d_writeback_i | mem_d_flush_i;

  // A pop in this cycle does not free a slot until the count register updates.
  assign w_accept = !rst_i && (r_count != CNT_W'(DEPTH));
  assign w_push   = w_req && w_accept;
  assign w_pop    = (r_count != '0) && (r_q_cd[r_rd_ptr] == 4'd0);

  // Writes win over reads, reads win over cache maintenance.
  assign w_is_wr = |mem_d_wr_i;
  assign w_is_rd = mem_d_rd_i && !w_is_wr;

  // 33-bit subtraction: a borrow means below base, high bits set means past end.
  assign w_offset   = {1'b0, mem_d_addr_i} - {1'b0, BASE_ADDR};
  assign w_in_range = (w_offset[32:ADDR_BITS+2] == '0);
  assign w_word_idx = w_offset[ADDR_BITS+1:2];

  assign w_unused = &{1'b0, mem_d_cacheable_i, w_offset[1:0]};

  // One byte-wide array per lane so each strobe has its own write port.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_lane [WORDS];

    // Byte write on the accepting edge; storage is never cleared by reset.
    always_ff @(posedge clk_i) begin
      if (w_push && w_is_wr && w_in_range && mem_d_wr_i[gi]) begin
        r_lane[w_word_idx] <= mem_d_data_wr_i[gi*8 +: 8];
      end
    end

    assign w_rd_word[gi*8 +: 8] = r_lane[w_word_idx];
  end

  // FIFO push/pop, per-entry countdown and the one-cycle response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_data   <= '0;
      r_tag    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_q_cd[i] != 4'd0) begin
          r_q_cd[i] <= r_q_cd[i] - 4'd1;
        end
      end

      if (w_push) begin
        r_q_tag[r_wr_ptr]  <= mem_d_req_tag_i;
        r_q_data[r_wr_ptr] <= (w_is_rd && w_in_range) ? w_rd_word : 32'd0;
        r_q_err[r_wr_ptr]  <= !w_in_range;
        r_q_cd[r_wr_ptr]   <= 4'(LATENCY - 1);
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end

      if (w_pop) begin
        r_ack    <= 1'b1;
        r_err    <= r_q_err[r_rd_ptr];
        r_data   <= r_q_data[r_rd_ptr];
        r_tag    <= r_q_tag[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end else begin
        r_ack  <= 1'b0;
        r_err  <= 1'b0;
        r_data <= '0;
        r_tag  <= '0;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign mem_d_accept_o   = w_accept;
  assign mem_d_ack_o      = r_ack;
  assign mem_d_error_o    = r_err;
  assign mem_d_data_rd_o  = r_data;
  assign mem_d_resp_tag_o = r_tag;

endmodule

// File: tb/tb_tcm_dport_responder.sv
// Scoreboard bench: unit 0 runs with LATENCY=2, unit 1 with LATENCY=8.
// The driver pushes the hand-computed response and its due time into a
// per-unit queue; a negedge monitor pops and compares every ack.
module tb_tcm_dport_responder;

  typedef struct {
    logic [10:0] tag;
    logic [31:0] data;
    logic        err;
    longint      t;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        rd    [2];
  logic [3:0]  wr    [2];
  logic        fl    [2];
  logic [10:0] tag   [2];
  logic [31:0] rdata [2];
  logic        acc   [2];
  logic        ack   [2];
  logic        err   [2];
  logic [10:0] rtag  [2];

  exp_t   q0[$];
  exp_t   q1[$];
  longint last_t [2];
  int     n_checks = 0;
  int     n_pass   = 0;

  tcm_dport_responder #(.LATENCY(2)) u_dut_l2 (
    .clk_i(clk), .rst_i(rst),
    .mem_d_addr_i(addr[0]), .mem_d_data_wr_i(wdata[0]), .mem_d_rd_i(rd[0]),
    .mem_d_wr_i(wr[0]), .mem_d_cacheable_i(1'b0), .mem_d_req_tag_i(tag[0]),
    .mem_d_invalidate_i(1'b0), .mem_d_writeback_i(1'b0), .mem_d_flush_i(fl[0]),
    .mem_d_data_rd_o(rdata[0]), .mem_d_accept_o(acc[0]), .mem_d_ack_o(ack[0]),
    .mem_d_error_o(err[0]), .mem_d_resp_tag_o(rtag[0])
  );

  tcm_dport_responder #(.LATENCY(8)) u_dut_l8 (
    .clk_i(clk), .rst_i(rst),
    .mem_d_addr_i(addr[1]), .mem_d_data_wr_i(wdata[1]), .mem_d_rd_i(rd[1]),
    .mem_d_wr_i(wr[1]), .mem_d_cacheable_i(1'b0), .mem_d_req_tag_i(tag[1]),
    .mem_d_invalidate_i(1'b0), .mem_d_writeback_i(1'b0), .mem_d_flush_i(fl[1]),
    .mem_d_data_rd_o(rdata[1]), .mem_d_accept_o(acc[1]), .mem_d_ack_o(ack[1]),
    .mem_d_error_o(err[1]), .mem_d_resp_tag_o(rtag[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic idle();
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0; wr[u] = 4'h0; fl[u] = 1'b0;
      addr[u] = '0; wdata[u] = '0; tag[u] = '0;
    end
  endtask

  // Present one request, wait for accept, then record the expected response.
  task automatic issue(input int u, input logic r, input logic [3:0] w, input logic f,
                       input logic [31:0] a, input logic [31:0] d, input logic [10:0] t,
                       input logic [31:0] exp_d, input logic exp_e);
    int     waited;
    longint t_acc;
    longint due;
    exp_t   e;
    @(negedge clk);
    rd[u] = r; wr[u] = w; fl[u] = f; addr[u] = a; wdata[u] = d; tag[u] = t;
    waited = 0;
    while (!acc[u] && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!acc[u]) begin
      chk($sformatf("u%0d_accept_timeout_tag%h", u, t), 64'(acc[u]), 64'd1);
    end else begin
      @(posedge clk);
      t_acc = $time;
      due = t_acc + ((u == 0) ? 2 : 8) * 10 + 5;
      if (due < last_t[u] + 10) due = last_t[u] + 10;
      last_t[u] = due;
      e.tag = t; e.data = exp_d; e.err = exp_e; e.t = due;
      $display("issue u%0d tag=%h addr=%h rd=%0b wr=%h fl=%0b accepted_at=%0t", u, t, a, r, w, f, t_acc);
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("drain_outstanding", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  // Monitor: compare every ack against the queue head; idle outputs must be 0.
  always @(negedge clk) begin
    exp_t e;
    int   sz;
    for (int u = 0; u < 2; u++) begin
      if (ack[u]) begin
        sz = (u == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
          chk($sformatf("u%0d_unexpected_ack_tag%h", u, rtag[u]), 64'(ack[u]), 64'd0);
        end else begin
          if (u == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          $display("ack u%0d tag=%h data=%h err=%0b t=%0t", u, rtag[u], rdata[u], err[u], $time);
          chk($sformatf("u%0d_tag", u), 64'(rtag[u]), 64'(e.tag));
          chk($sformatf("u%0d_data_tag%h", u, e.tag), 64'(rdata[u]), 64'(e.data));
          chk($sformatf("u%0d_err_tag%h", u, e.tag), 64'(err[u]), 64'(e.err));
          chk($sformatf("u%0d_time_tag%h", u, e.tag), 64'($time), 64'(e.t));
        end
      end else begin
        chk($sformatf("u%0d_idle_zero", u), 64'({rdata[u], rtag[u], err[u]}), 64'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    last_t[0] = 0; last_t[1] = 0;
    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0; wr[u] = 4'h0; fl[u] = 1'b0;
      addr[u] = '0; wdata[u] = '0; tag[u] = '0;
    end

    // Reset held with a read pending: nothing accepted, nothing acked.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rd[0] = 1'b1; rd[1] = 1'b1;
      addr[0] = 32'h80000000; addr[1] = 32'h80000000;
      #1;
      chk("reset_accept_u0", 64'(acc[0]), 64'd0);
      chk("reset_accept_u1", 64'(acc[1]), 64'd0);
    end
    @(negedge clk);
    rd[0] = 1'b0; rd[1] = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_reset_accept_u0", 64'(acc[0]), 64'd1);
    chk("post_reset_accept_u1", 64'(acc[1]), 64'd1);

    // Full write, read back, byte-lane write, back-to-back read.
    issue(0, 1'b0, 4'hF, 1'b0, 32'h80000010, 32'hDEADBEEF, 11'h005, 32'h0, 1'b0);
    idle();
    repeat (4) idle();
    issue(0, 1'b1, 4'h0, 1'b0, 32'h80000010, 32'h0, 11'h006, 32'hDEADBEEF, 1'b0);
    idle();
    repeat (4) idle();
    issue(0, 1'b0, 4'b0010, 1'b0, 32'h80000010, 32'h0000AA00, 11'h007, 32'h0, 1'b0);
    issue(0, 1'b1, 4'h0, 1'b0, 32'h80000010, 32'h0, 11'h008, 32'hDEADAAEF, 1'b0);
    idle();
    repeat (4) idle();
    issue(0, 1'b1, 4'h0, 1'b0, 32'h80000010, 32'h0, 11'h009, 32'hDEADAAEF, 1'b0);
    idle();

    // Range errors: below base, one past the end; word 0 must survive.
    issue(0, 1'b0, 4'hF, 1'b0, 32'h80000000, 32'h0BADF00D, 11'h020, 32'h0, 1'b0);
    issue(0, 1'b1, 4'h0, 1'b0, 32'h00000000, 32'h0, 11'h7FF, 32'h0, 1'b1);
    issue(0, 1'b0, 4'hF, 1'b0, 32'h7FFFFFFC, 32'hFFFFFFFF, 11'h021, 32'h0, 1'b1);
    issue(0, 1'b0, 4'hF, 1'b0, 32'h80020000, 32'hFFFFFFFF, 11'h022, 32'h0, 1'b1);
    issue(0, 1'b1, 4'h0, 1'b0, 32'h80000000, 32'h0, 11'h023, 32'h0BADF00D, 1'b0);
    // Maintenance returns 0; rd together with wr is treated as a write.
    issue(0, 1'b0, 4'h0, 1'b1, 32'h80000010, 32'h0, 11'h024, 32'h0, 1'b0);
    issue(0, 1'b1, 4'hF, 1'b0, 32'h80000014, 32'h11112222, 11'h025, 32'h0, 1'b0);
    issue(0, 1'b1, 4'h0, 1'b0, 32'h80000014, 32'h0, 11'h026, 32'h11112222, 1'b0);
    idle();
    drain();

    // LATENCY=8: fill all four slots, fifth waits for the first pop and wraps.
    issue(1, 1'b0, 4'hF, 1'b0, 32'h80000020, 32'h12345678, 11'h010, 32'h0, 1'b0);
    idle();
    drain();
    for (int i = 1; i <= 4; i++) begin
      issue(1, 1'b1, 4'h0, 1'b0, 32'h80000020, 32'h0, 11'(i), 32'h12345678, 1'b0);
    end
    idle();
    #1;
    chk("full_accept_low", 64'(acc[1]), 64'd0);
    issue(1, 1'b1, 4'h0, 1'b0, 32'h80000020, 32'h0, 11'h005, 32'h12345678, 1'b0);
    idle();
    drain();

    // Reset with three reads in flight: they are discarded, memory is kept.
    for (int i = 0; i < 3; i++) begin
      issue(1, 1'b1, 4'h0, 1'b0, 32'h80000020, 32'h0, 11'(8'h31 + i), 32'h12345678, 1'b0);
    end
    idle();
    @(negedge clk);
    rst = 1'b1;
    q1.delete();
    last_t[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) idle();
    issue(1, 1'b1, 4'h0, 1'b0, 32'h80000020, 32'h0, 11'h034, 32'h12345678, 1'b0);
    idle();
    drain();

    repeat (20) idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
